// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes 32-bit words to imem, then releases the core.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module program_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        imem_wr_en,
   output logic [31:0] imem_wr_addr,
   output logic [31:0] imem_wr_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        core_run,
   output logic [15:0] words_loaded
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_TAIL   = S_CHECK;
`else
   localparam logic [2:0] S_TAIL   = S_DONE;
`endif
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   logic [2:0]  state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [23:0] part_q, part_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] words_q, words_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        accepting;
   logic        xfer;
   logic [15:0] hdr_len;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   assign accepting = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
`else
   assign accepting = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA);
`endif
   assign xfer    = accepting && byte_valid;
   assign hdr_len = {byte_in, len_q[7:0]};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      len_d     = len_q;
      part_d    = part_q;
      idx_d     = idx_q;
      words_d   = words_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_LO;
               words_d = 16'd0;
               idx_d   = 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d   = {len_q[15:8], byte_in};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = hdr_len;
               if (hdr_len == 16'd0)                 state_d = S_TAIL;
               else if ({1'b0, hdr_len} > MAX_LEN)   state_d = S_ERROR;
               else                                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_in;
`endif
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: part_d[7:0]   = byte_in;
                  2'd1: part_d[15:8]  = byte_in;
                  2'd2: part_d[23:16] = byte_in;
                  default: begin
                     // Word complete: the strobe appears in the following cycle with the pre-increment address.
                     wr_en_d   = 1'b1;
                     wr_addr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
                     wr_data_d = {byte_in, part_q};
                     words_d   = words_q + 16'd1;
                     if (words_d == len_q) state_d = S_TAIL;
                  end
               endcase
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) state_d = (byte_in == csum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_q     <= 16'd0;
         part_q    <= 24'd0;
         idx_q     <= 2'd0;
         words_q   <= 16'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 32'd0;
         wr_data_q <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q    <= 8'h00;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         len_q     <= len_d;
         part_q    <= part_d;
         idx_q     <= idx_d;
         words_q   <= words_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   // done/core_run wait out a pending final write so the core never fetches ahead of it.
   assign byte_ready   = accepting;
   assign imem_wr_en   = wr_en_q;
   assign imem_wr_addr = wr_addr_q;
   assign imem_wr_data = wr_data_q;
   assign busy         = accepting || wr_en_q;
   assign done         = (state_q == S_DONE) && !wr_en_q;
   assign core_run     = (state_q == S_DONE) && !wr_en_q;
   assign error        = (state_q == S_ERROR);
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; one task per scenario.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready, imem_wr_en, busy, done, error, core_run;
   logic [31:0] imem_wr_addr, imem_wr_data;
   logic [15:0] words_loaded;

   int errors = 0;
   int checks = 0;

   int          wr_cnt = 0;
   logic [31:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];

   logic [7:0]  stim [16];
   int          stim_n;

   program_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .busy(busy), .done(done), .error(error), .core_run(core_run),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_wr_en === 1'b1) begin
         if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] = imem_wr_addr;
            wr_data_log[wr_cnt] = imem_wr_data;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk); byte_valid = 1'b0; byte_in = 8'hEE;
      end
      @(negedge clk); byte_in = b; byte_valid = 1'b1; n = 0;
      while (byte_ready !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL handshake_timeout: byte_ready=%b required 1", byte_ready);
      end else begin
         @(posedge clk);
      end
      #1 byte_valid = 1'b0;
   endtask

   task automatic send_stim(input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) send_byte(stim[i], gap);
   endtask

   function automatic logic [7:0] data_xor();
      logic [7:0] x = 8'h00;
      for (int i = 2; i < stim_n; i++) x = x ^ stim[i];
      return x;
   endfunction

   task automatic load_two_word_stim();
      stim[0] = 8'h02; stim[1] = 8'h00;
      stim[2] = 8'h13; stim[3] = 8'h05; stim[4] = 8'hA0; stim[5] = 8'h00;
      stim[6] = 8'h93; stim[7] = 8'h05; stim[8] = 8'hB0; stim[9] = 8'h00;
      stim_n = 10;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      checks++; if ({byte_ready, imem_wr_en, busy, done, error, core_run} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 000000",
                            {byte_ready, imem_wr_en, busy, done, error, core_run});
      end
      checks++; if ({imem_wr_addr, imem_wr_data, words_loaded} !== 80'd0) begin
         errors++; $display("FAIL reset_buses: addr=%h data=%h words=%0d required 0",
                            imem_wr_addr, imem_wr_data, words_loaded);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({byte_ready, busy} !== 2'b00) begin
         errors++; $display("FAIL idle_not_ready: ready/busy=%b required 00", {byte_ready, busy});
      end
   endtask

   task automatic test_basic_load(input int gap, input string tag);
      int base;
      load_two_word_stim();
      pulse_start();
      checks++; if ({busy, byte_ready, done, core_run} !== 4'b1100 || words_loaded !== 16'd0) begin
         errors++; $display("FAIL %s_after_start: busy/ready/done/run=%b words=%0d required 1100 0",
                            tag, {busy, byte_ready, done, core_run}, words_loaded);
      end
      base = wr_cnt;
      send_stim(0, stim_n - 1, gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(data_xor(), gap);
`else
      checks++; if (imem_wr_en !== 1'b1 || done !== 1'b0 || core_run !== 1'b0) begin
         errors++; $display("FAIL %s_last_pulse: wr_en=%b done=%b run=%b required 1 0 0",
                            tag, imem_wr_en, done, core_run);
      end
      @(posedge clk); #1;
`endif
      checks++; if ({done, core_run, busy, error, byte_ready} !== 5'b11000) begin
         errors++; $display("FAIL %s_done: done/run/busy/err/ready=%b required 11000",
                            tag, {done, core_run, busy, error, byte_ready});
      end
      checks++; if (words_loaded !== 16'd2 || wr_cnt - base !== 2) begin
         errors++; $display("FAIL %s_count: words=%0d writes=%0d required 2 2",
                            tag, words_loaded, wr_cnt - base);
      end
      checks++; if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h00A00513) begin
         errors++; $display("FAIL %s_word0: %h@%h required 00a00513@00000000",
                            tag, wr_data_log[base], wr_addr_log[base]);
      end
      checks++; if (wr_addr_log[base+1] !== 32'h4 || wr_data_log[base+1] !== 32'h00B00593) begin
         errors++; $display("FAIL %s_word1: %h@%h required 00b00593@00000004",
                            tag, wr_data_log[base+1], wr_addr_log[base+1]);
      end
   endtask

   task automatic test_reset_mid_data();
      int base;
      load_two_word_stim();
      pulse_start();
      send_stim(0, 5, 0);
      @(negedge clk); byte_in = 8'h93; byte_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({byte_ready, imem_wr_en, busy, done, error, core_run} !== 6'b0 ||
                    words_loaded !== 16'd0 || imem_wr_addr !== 32'd0 || imem_wr_data !== 32'd0) begin
         errors++; $display("FAIL midreset_outputs: flags=%b words=%0d addr=%h data=%h required 0",
                            {byte_ready, imem_wr_en, busy, done, error, core_run},
                            words_loaded, imem_wr_addr, imem_wr_data);
      end
      base = wr_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (wr_cnt !== base || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_quiet: writes=%0d busy=%b required 0 0", wr_cnt - base, busy);
      end
   endtask

   task automatic test_too_long();
      int base;
      base = wr_cnt;
      pulse_start();
      stim[0] = 8'h01; stim[1] = 8'h01; stim_n = 2;
      send_stim(0, 1, 0);
      checks++; if ({error, core_run, done, busy, byte_ready} !== 5'b10000) begin
         errors++; $display("FAIL toolong_error: err/run/done/busy/ready=%b required 10000",
                            {error, core_run, done, busy, byte_ready});
      end
      repeat (2) @(negedge clk);
      checks++; if (wr_cnt !== base || error !== 1'b1) begin
         errors++; $display("FAIL toolong_nowrite: writes=%0d err=%b required 0 1", wr_cnt - base, error);
      end
      pulse_start();
      checks++; if ({error, busy, byte_ready, done} !== 4'b0110) begin
         errors++; $display("FAIL toolong_restart: err/busy/ready/done=%b required 0110",
                            {error, busy, byte_ready, done});
      end
      stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_stim(0, 2, 0);
`else
      send_stim(0, 1, 0);
`endif
      checks++; if ({done, core_run} !== 2'b11) begin
         errors++; $display("FAIL toolong_recover: done/run=%b required 11", {done, core_run});
      end
   endtask

   task automatic test_zero_len();
      int base;
      base = wr_cnt;
      pulse_start();
      stim[0] = 8'h00; stim[1] = 8'h00; stim_n = 2;
      send_stim(0, 1, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checks++; if (done !== 1'b0 || byte_ready !== 1'b1) begin
         errors++; $display("FAIL zero_check_state: done=%b ready=%b required 0 1", done, byte_ready);
      end
      send_byte(data_xor(), 0);
`endif
      checks++; if ({done, core_run, error} !== 3'b110 || words_loaded !== 16'd0 || wr_cnt !== base) begin
         errors++; $display("FAIL zero_done: done/run/err=%b words=%0d writes=%0d required 110 0 0",
                            {done, core_run, error}, words_loaded, wr_cnt - base);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      pulse_start();
      send_stim(0, 1, 0);
      send_byte(8'hFF, 0);
      checks++; if ({error, core_run, done} !== 3'b100 || wr_cnt !== base) begin
         errors++; $display("FAIL zero_bad_sum: err/run/done=%b writes=%0d required 100 0",
                            {error, core_run, done}, wr_cnt - base);
      end
`endif
   endtask

   task automatic test_start_ignored();
      int base;
      base = wr_cnt;
      pulse_start();
      stim[0] = 8'h01; stim[1] = 8'h00;
      stim[2] = 8'h13; stim[3] = 8'h00; stim[4] = 8'h00; stim[5] = 8'h00;
      stim_n = 6;
      send_stim(0, 3, 0);
      pulse_start();
      checks++; if (busy !== 1'b1 || byte_ready !== 1'b1 || words_loaded !== 16'd0) begin
         errors++; $display("FAIL ignore_start_state: busy=%b ready=%b words=%0d required 1 1 0",
                            busy, byte_ready, words_loaded);
      end
      send_stim(4, 5, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h12, 0);
      checks++; if ({error, core_run, done} !== 3'b100) begin
         errors++; $display("FAIL ignore_bad_sum: err/run/done=%b required 100", {error, core_run, done});
      end
`else
      @(posedge clk); #1;
      checks++; if ({done, core_run, error} !== 3'b110) begin
         errors++; $display("FAIL ignore_done: done/run/err=%b required 110", {done, core_run, error});
      end
`endif
      checks++; if (wr_cnt - base !== 1 || words_loaded !== 16'd1) begin
         errors++; $display("FAIL ignore_count: writes=%0d words=%0d required 1 1", wr_cnt - base, words_loaded);
      end
      checks++; if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h00000013) begin
         errors++; $display("FAIL ignore_word: %h@%h required 00000013@00000000",
                            wr_data_log[base], wr_addr_log[base]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load(0, "basic");
      test_basic_load(2, "gaps");
      test_reset_mid_data();
      test_basic_load(0, "after_reset");
      test_too_long();
      test_zero_len();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
